// File: rtl/uart_receiver.sv
// 8N1 UART receiver into a FWFT FIFO; byte visible one cycle after the mid-stop sample.
// Backpressure: valid/ready pop; a good byte arriving while full (and no pop) is dropped with an overrun pulse.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int DEPTH        = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     IN,
   output logic [7:0]               data,
   output logic                     valid,
   input  logic                     ready,
   output logic                     frame_err,
   output logic                     overrun,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic          sync1, rxs;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          full, pop, push_req, push;

   // Bit-centre tick shared by DATA and STOP; START uses the half-bit tick.
   logic bit_tick, half_tick;
   assign bit_tick  = (cnt == CW'(CLKS_PER_BIT - 1));
   assign half_tick = (cnt == CW'(HALF - 1));

   assign push_req = (state == S_STOP) && bit_tick && rxs;
   assign full     = (level == LW'(DEPTH));
   assign valid    = (level != '0);
   assign pop      = valid && ready;
   assign push     = push_req && (!full || pop);
   assign data     = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1     <= 1'b1;
         rxs       <= 1'b1;
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         sync1     <= IN;
         rxs       <= sync1;
         frame_err <= 1'b0;
         cnt       <= cnt + 1'b1;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (!rxs) state <= S_START;
            end
            S_START: begin
               if (half_tick) begin
                  cnt <= '0;
                  if (!rxs) begin
                     state   <= S_DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (bit_tick) begin
                  cnt     <= '0;
                  shreg   <= {rxs, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= S_STOP;
               end
            end
            S_STOP: begin
               if (bit_tick) begin
                  cnt <= '0;
                  if (rxs) begin
                     state <= S_IDLE;
                  end else begin
                     state     <= S_BREAK;
                     frame_err <= 1'b1;
                  end
               end
            end
            S_BREAK: begin
               // A line held low after a bad stop bit must not look like a new start bit.
               cnt <= '0;
               if (rxs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         overrun <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         overrun <= push_req && full && !pop;
         if (push) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push) - LW'(pop);
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with CLKS_PER_BIT=16, DEPTH=4.
module tb_uart_receiver;

   localparam int CPB = 16;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       IN = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid, frame_err, overrun;
   logic [2:0] level;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int fe_cnt  = 0, fe_cyc = -1;
   int ov_cnt  = 0;
   int vr_cyc  = -1;
   logic prev_valid = 1'b0;
   int t0, fe0, ov0;

   uart_receiver #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .IN(IN), .data(data), .valid(valid), .ready(ready),
      .frame_err(frame_err), .overrun(overrun), .level(level)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
      if (overrun) ov_cnt++;
      if (valid && !prev_valid) vr_cyc = cyc;
      prev_valid = valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Entered at a negedge; t0 is the first cycle the line is low.
   task automatic send(input logic [7:0] b, input logic stop);
      t0 = cyc;
      IN = 1'b0;
      repeat (CPB) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         IN = b[i];
         repeat (CPB) @(negedge CLK);
      end
      IN = stop;
      repeat (CPB) @(negedge CLK);
   endtask

   task automatic pop_one(input string tag, input logic [7:0] exp);
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_data"}, 32'(data), 32'(exp));
      ready = 1'b1;
      @(negedge CLK);
      ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);

      // 1: single good frame, push visible at t_s+153 = t0+155
      fe0 = fe_cnt; ov0 = ov_cnt;
      send(8'h55, 1'b1);
      chk("t1_rise_cyc", 32'(vr_cyc), 32'(t0 + 155));
      chk("t1_level", 32'(level), 32'd1);
      chk("t1_ferr", 32'(fe_cnt - fe0), 32'd0);
      chk("t1_ovr", 32'(ov_cnt - ov0), 32'd0);
      pop_one("t1", 8'h55);
      chk("t1_empty", 32'(valid), 32'd0);

      // 2: short glitch is ignored
      IN = 1'b0;
      repeat (4) @(negedge CLK);
      IN = 1'b1;
      repeat (2 * CPB) @(negedge CLK);
      chk("t2_glitch_valid", 32'(valid), 32'd0);
      chk("t2_glitch_ferr", 32'(fe_cnt - fe0), 32'd0);
      send(8'hA3, 1'b1);
      pop_one("t2", 8'hA3);

      // 3: bad stop bit, line held low, then recovery
      fe0 = fe_cnt;
      send(8'h3C, 1'b0);
      repeat (40) @(negedge CLK);
      chk("t3_ferr_cnt", 32'(fe_cnt - fe0), 32'd1);
      chk("t3_ferr_cyc", 32'(fe_cyc), 32'(t0 + 155));
      chk("t3_no_push", 32'(valid), 32'd0);
      IN = 1'b1;
      repeat (2 * CPB) @(negedge CLK);
      chk("t3_break_quiet", 32'(fe_cnt - fe0), 32'd1);
      send(8'h0F, 1'b1);
      chk("t3_level", 32'(level), 32'd1);
      pop_one("t3", 8'h0F);
      chk("t3_empty", 32'(valid), 32'd0);

      // 4: overrun on fifth byte, then consecutive drain
      ov0 = ov_cnt;
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
      chk("t4_level4", 32'(level), 32'd4);
      send(8'h05, 1'b1);
      chk("t4_ovr", 32'(ov_cnt - ov0), 32'd1);
      chk("t4_level_full", 32'(level), 32'd4);
      ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("t4_drain", 32'(data), 32'(i));
         @(negedge CLK);
      end
      ready = 1'b0;
      chk("t4_empty", 32'(valid), 32'd0);
      chk("t4_level0", 32'(level), 32'd0);

      // 5: pop in the exact push cycle while full avoids overrun
      ov0 = ov_cnt;
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
      fork
         send(8'h05, 1'b1);
         begin
            repeat (154) @(negedge CLK);
            chk("t5_head_at_push", 32'(data), 32'd1);
            chk("t5_full_at_push", 32'(level), 32'd4);
            ready = 1'b1;
            @(negedge CLK);
            ready = 1'b0;
         end
      join
      chk("t5_ovr", 32'(ov_cnt - ov0), 32'd0);
      chk("t5_level", 32'(level), 32'd4);
      ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         chk("t5_drain", 32'(data), 32'(i));
         @(negedge CLK);
      end
      ready = 1'b0;
      chk("t5_empty", 32'(valid), 32'd0);

      // 6: reset mid-frame clears FIFO and partial byte
      send(8'h5A, 1'b1);
      chk("t6_pre_valid", 32'(valid), 32'd1);
      IN = 1'b0;
      repeat (CPB) @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         IN = i[0];
         repeat (CPB) @(negedge CLK);
      end
      IN = 1'b1;
      repeat (CPB / 2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("t6_rst_valid", 32'(valid), 32'd0);
      chk("t6_rst_level", 32'(level), 32'd0);
      repeat (3 * CPB) @(negedge CLK);
      chk("t6_quiet", 32'(valid), 32'd0);
      send(8'hC3, 1'b1);
      chk("t6_level", 32'(level), 32'd1);
      pop_one("t6", 8'hC3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
